muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit. Sits directly downstream of the register file: consumes `read_data1`/`read_data2` as operands and produces a 32-bit result plus destination index for the write-back path (`write_data`/`rd`). Operations run over 32 radix-2 iterations under a start/done handshake, so the processor stalls on `busy`.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/muldiv_unit.sv | 113 +++++++++++
 tb/tb_muldiv_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types, constants and negate helpers for the RV32M multiply/divide unit
package riscv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;
  localparam int MULDIV_ITER = 32;
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic n);
    return n ? ~v + 32'd1 : v;
  endfunction
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic n);
    return n ? ~v + 64'd1 : v;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, radix-2, 33-cycle start/done handshake.
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero, signed overflow and zero-operand multiplies in one cycle.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d, f;
  logic [31:0]   acc_q, acc_d, lo_q, lo_d, b_q, b_d, result_q, result_d, acc_s, lo_s, fin;
  logic [4:0]    rd_q, rd_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          neg_q, neg_d, sa, sb, ge;
  logic [32:0]   sum, shifted;
  logic [63:0]   pre, fix;
  assign f       = muldiv_op_t'(funct3);
  assign sa      = f inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign sb      = f inside {OP_MULH, OP_DIV, OP_REM};
  // Multiply: product lives in {acc, lo}, multiplier shifts out of lo. Divide: dividend shifts out of lo, quotient in.
  assign sum     = {1'b0, acc_q} + {1'b0, lo_q[0] ? b_q : 32'd0};
  assign shifted = {acc_q, lo_q[31]};
  assign ge      = shifted >= {1'b0, b_q};
  assign acc_s   = op_q[2] ? (ge ? shifted[31:0] - b_q : shifted[31:0]) : sum[32:1];
  assign lo_s    = op_q[2] ? {lo_q[30:0], ge} : {sum[0], lo_q[31:1]};
  assign pre     = op_q[2] ? {32'd0, op_q[1] ? acc_s : lo_s} : {acc_s, lo_s};
  assign fix     = cond_neg64(pre, neg_q);
  assign fin     = (op_q[2] || op_q == OP_MUL) ? fix[31:0] : fix[63:32];
`ifdef MULDIV_EARLY_OUT_EN
  logic dz, ovf, mz;
  assign dz  = funct3[2] && rs2_data == 32'd0;
  assign ovf = (f == OP_DIV || f == OP_REM) && rs1_data == 32'h8000_0000 && rs2_data == 32'hFFFF_FFFF;
  assign mz  = !funct3[2] && (rs1_data == 32'd0 || rs2_data == 32'd0);
`endif
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (state_q == CALC) begin
      acc_d = acc_s;
      lo_d  = lo_s;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(MULDIV_ITER - 1)) begin
        result_d = fin;
        state_d  = DONE;
      end
    end else if (start) begin
      op_d    = f;
      rd_d    = rd_in;
      lo_d    = cond_neg32(rs1_data, sa && rs1_data[31]);
      b_d     = cond_neg32(rs2_data, sb && rs2_data[31]);
      acc_d   = 32'd0;
      cnt_d   = 6'd0;
      // A zero divisor leaves an all-ones quotient, so DIV/0 must not be negated.
      neg_d   = f == OP_REM ? rs1_data[31] :
                f == OP_DIV ? (rs1_data[31] ^ rs2_data[31]) && rs2_data != 32'd0 :
                (sa && rs1_data[31]) ^ (sb && rs2_data[31]);
      state_d = CALC;
`ifdef MULDIV_EARLY_OUT_EN
      if (dz || ovf || mz) begin
        state_d  = DONE;
        result_d = mz ? 32'd0 : dz ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF) : (funct3[1] ? 32'd0 : 32'h8000_0000);
      end
`endif
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      acc_q    <= 32'd0;
      lo_q     <= 32'd0;
      b_q      <= 32'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end
  assign busy   = state_q == CALC;
  assign done   = state_q == DONE;
  assign result = result_q;
  assign rd_out = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0, rs2_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  int          total = 0, passed = 0;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SL = 1;
`else
  localparam int SL = 33;
`endif
  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; rs1_data = ~a; rs2_data = 32'd5; rd_in = ~rd;
    n = 1;
    if (lat > 1) chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, lat);
    chk({tag, ".res"}, result, exp);
    chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, rd});
    chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, ".done_once"}, {31'd0, done}, 32'd0);
    chk({tag, ".hold"}, result, exp);
  endtask
  initial begin
    int n, cnt, first;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.rd", {27'd0, rd_out}, 32'd0);
    rst_n = 1'b1;
    run("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33);
    run("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 33);
    run("mulh2",  3'd1, 32'h8000_0000, 32'd3,         5'd7,  32'hFFFF_FFFE, 33);
    run("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
    run("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
    run("divu",   3'd5, 32'd100,       32'd7,         5'd10, 32'd14,        33);
    run("remu",   3'd7, 32'd100,       32'd7,         5'd11, 32'd2,         33);
    run("divu0",  3'd5, 32'h1234,      32'd0,         5'd12, 32'hFFFF_FFFF, SL);
    run("remu0",  3'd7, 32'h1234,      32'd0,         5'd13, 32'h1234,      SL);
    run("div0n",  3'd4, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFFF, SL);
    run("rem0n",  3'd6, 32'hFFFF_FFF9, 32'd0,         5'd15, 32'hFFFF_FFF9, SL);
    run("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, SL);
    run("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         SL);
    run("mulz",   3'd0, 32'd0,         32'd9,         5'd18, 32'd0,         SL);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.done", {31'd0, done}, 32'd0);
    chk("midrst.res", result, 32'd0);
    chk("midrst.rd", {27'd0, rd_out}, 32'd0);
    rst_n = 1'b1;
    run("mul35", 3'd0, 32'd3, 32'd5, 5'd21, 32'd15, 33);
    @(negedge clk);
    start = 1'b1; funct3 = 3'd3; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (n == 5) begin start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd1; rd_in = 5'd2; end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk("ign.lat", n, 33);
    chk("ign.res", result, 32'hFFFF_FFFE);
    chk("ign.rd", {27'd0, rd_out}, 32'd9);
    @(negedge clk);
    chk("ign.noqueue", {31'd0, done | busy}, 32'd0);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; rd_in = 5'd22;
    cnt = 0; first = 0;
    for (int i = 1; i <= 99; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    start = 1'b0;
    chk("b2b.count", cnt, 3);
    chk("b2b.first", first, 33);
    chk("b2b.res", result, 32'd42);
    repeat (2) @(negedge clk);
    chk("b2b.idle", {31'd0, done | busy}, 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
